// File: rtl/aer_row_scheduler_16_if.sv
// AER row scheduler bus: row requests, off-chip
// handshake and status, with DUT/driver views.
interface aer_row_scheduler_16_if;
  logic [15:0] row_req;
  logic        greedy;
  logic        aer_dis;
  logic        aer_ack;
  logic [15:0] row_grant;
  logic        aer_req;
  logic [3:0]  aer_addr;
  logic        busy;
  logic [15:0] evt_cnt;

  modport master (
    output row_req,
    output greedy,
    output aer_dis,
    output aer_ack,
    input  row_grant,
    input  aer_req,
    input  aer_addr,
    input  busy,
    input  evt_cnt
  );

  modport slave (
    input  row_req,
    input  greedy,
    input  aer_dis,
    input  aer_ack,
    output row_grant,
    output aer_req,
    output aer_addr,
    output busy,
    output evt_cnt
  );
endinterface

// File: rtl/aer_row_scheduler_16.sv
// 16-row AER scheduler: rotating-priority arbiter
// feeding a 4-phase off-chip request/ack handshake.
module aer_row_scheduler_16 (
  input logic               clk,
  input logic               rst,
  aer_row_scheduler_16_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACK,
    RELEASE
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [3:0]  r_ptr;
  logic [3:0]  w_ptr_nx;
  logic [3:0]  r_win;
  logic [3:0]  w_win_nx;
  logic [15:0] r_grant;
  logic [15:0] w_grant_nx;
  logic        r_req;
  logic        w_req_nx;
  logic [3:0]  r_addr;
  logic [3:0]  w_addr_nx;
  logic        r_busy;
  logic        w_busy_nx;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nx;

  logic        w_any;
  logic [3:0]  w_pick;

  assign w_any = |bus.row_req;

  // First requesting row at or after ptr, wrapping.
  always_comb begin
    logic [3:0] v_idx;
    v_idx  = '0;
    w_pick = r_ptr;
    for (int k = 15; k >= 0; k--) begin
      v_idx = r_ptr + 4'(k);
      if (bus.row_req[v_idx]) begin
        w_pick = v_idx;
      end
    end
  end

  // Next-state and next-output logic for the handshake.
  always_comb begin
    w_state_nx = r_state;
    w_ptr_nx   = r_ptr;
    w_win_nx   = r_win;
    w_grant_nx = r_grant;
    w_req_nx   = r_req;
    w_addr_nx  = r_addr;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_any && !bus.aer_dis) begin
          w_state_nx = REQ;
          w_win_nx   = w_pick;
          w_grant_nx = 16'd1 << w_pick;
          w_addr_nx  = w_pick;
          w_req_nx   = 1'b1;
        end
      end
      REQ: begin
        if (bus.aer_ack) begin
          w_state_nx = ACK;
          w_req_nx   = 1'b0;
        end
      end
      ACK: begin
        if (!bus.aer_ack) begin
          w_state_nx = RELEASE;
          w_grant_nx = '0;
          if (r_cnt != 16'hFFFF) begin
            w_cnt_nx = r_cnt + 16'd1;
          end
          if (bus.greedy) begin
            w_ptr_nx = r_win;
          end else begin
            w_ptr_nx = r_win + 4'd1;
          end
        end
      end
      RELEASE: begin
        if (!bus.row_req[r_win]) begin
          w_state_nx = IDLE;
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_grant_nx = '0;
        w_req_nx   = 1'b0;
      end
    endcase
    w_busy_nx = (w_state_nx != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_grant <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ptr   <= w_ptr_nx;
      r_win   <= w_win_nx;
      r_grant <= w_grant_nx;
      r_req   <= w_req_nx;
      r_addr  <= w_addr_nx;
      r_busy  <= w_busy_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign bus.row_grant = r_grant;
  assign bus.aer_req   = r_req;
  assign bus.aer_addr  = r_addr;
  assign bus.busy      = r_busy;
  assign bus.evt_cnt   = r_cnt;

endmodule

// File: tb/tb_aer_row_scheduler_16.sv
// Bench for aer_row_scheduler_16: directed scenarios
// plus random traffic against a transaction model.
module tb_aer_row_scheduler_16;

  logic clk;
  logic rst;
  aer_row_scheduler_16_if bus();

  aer_row_scheduler_16 dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // model: phase 0 idle, 1 await ack high,
  // 2 await ack low, 3 await winner row drop
  int          m_ph;
  int          m_ptr;
  int          m_w;
  logic [15:0] e_grant;
  logic        e_req;
  logic [3:0]  e_addr;
  logic        e_busy;
  logic [15:0] e_cnt;

  logic [3:0]  g_addr;
  logic [15:0] g_grant;
  int          g_lat;
  int          g_drop;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: no event in 20 cycles", nm);
  endtask

  task automatic m_reset();
    m_ph    = 0;
    m_ptr   = 0;
    m_w     = 0;
    e_grant = '0;
    e_req   = 1'b0;
    e_addr  = '0;
    e_busy  = 1'b0;
    e_cnt   = '0;
  endtask

  task automatic m_step();
    case (m_ph)
      0: begin
        if (bus.row_req != 0 && !bus.aer_dis) begin
          m_w = -1;
          for (int k = 0; k < 16; k++) begin
            if (m_w < 0 &&
                bus.row_req[(m_ptr + k) % 16])
              m_w = (m_ptr + k) % 16;
          end
          e_grant = 16'd1 << m_w;
          e_addr  = 4'(m_w);
          e_req   = 1'b1;
          m_ph    = 1;
        end
      end
      1: begin
        if (bus.aer_ack) begin
          e_req = 1'b0;
          m_ph  = 2;
        end
      end
      2: begin
        if (!bus.aer_ack) begin
          e_grant = '0;
          if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 1;
          if (bus.greedy) m_ptr = m_w;
          else m_ptr = (m_w + 1) % 16;
          m_ph = 3;
        end
      end
      default: begin
        if (!bus.row_req[m_w]) m_ph = 0;
      end
    endcase
    e_busy = (m_ph != 0);
  endtask

  task automatic compare();
    check("row_grant", 32'(bus.row_grant), 32'(e_grant));
    check("aer_req", 32'(bus.aer_req), 32'(e_req));
    check("busy", 32'(bus.busy), 32'(e_busy));
    check("evt_cnt", 32'(bus.evt_cnt), 32'(e_cnt));
    check("onehot",
          32'($countones(bus.row_grant) <= 1), 32'd1);
    if (e_req)
      check("aer_addr", 32'(bus.aer_addr), 32'(e_addr));
  endtask

  task automatic step();
    m_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_grant", 32'(bus.row_grant), 32'd0);
    check("rst_req", 32'(bus.aer_req), 32'd0);
    check("rst_addr", 32'(bus.aer_addr), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cnt", 32'(bus.evt_cnt), 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    compare();
    rst = 1'b0;
  endtask

  task automatic clr_in();
    bus.row_req = '0;
    bus.aer_ack = 1'b0;
    bus.aer_dis = 1'b0;
    bus.greedy  = 1'b0;
  endtask

  task automatic run_txn(input logic [15:0] rq,
                         input int dly,
                         input bit dis_in_ack);
    int n;
    bus.row_req = rq;
    bus.aer_ack = 1'b0;
    n = 0;
    while (!bus.aer_req && n < 20) begin
      step();
      n++;
    end
    g_lat = n;
    if (!bus.aer_req) begin
      tmo("wait_req");
      return;
    end
    g_addr  = bus.aer_addr;
    g_grant = bus.row_grant;
    repeat (dly) step();
    bus.aer_ack = 1'b1;
    n = 0;
    while (bus.aer_req && n < 20) begin
      step();
      n++;
    end
    g_drop = n;
    if (bus.aer_req) begin
      tmo("wait_drop");
      return;
    end
    if (dis_in_ack) bus.aer_dis = 1'b1;
    step();
    bus.aer_ack = 1'b0;
    n = 0;
    while (bus.row_grant != 0 && n < 20) begin
      step();
      n++;
    end
    if (bus.row_grant != 0) begin
      tmo("wait_rel");
      return;
    end
    bus.row_req = rq & ~(16'd1 << g_addr);
    step();
    bus.row_req = rq;
  endtask

  task automatic rnd_inputs();
    if ($urandom_range(0, 2) == 0)
      bus.row_req[$urandom_range(0, 15)] ^= 1'b1;
    if ($urandom_range(0, 99) == 0)
      bus.row_req = 16'($urandom);
    if (bus.aer_req && !bus.aer_ack) begin
      if ($urandom_range(0, 2) == 0) bus.aer_ack = 1'b1;
    end else if (!bus.aer_req && bus.aer_ack) begin
      if ($urandom_range(0, 2) == 0) bus.aer_ack = 1'b0;
    end else if ($urandom_range(0, 19) == 0) begin
      bus.aer_ack = ~bus.aer_ack;
    end
    if ($urandom_range(0, 49) == 0)
      bus.greedy = ~bus.greedy;
    if ($urandom_range(0, 39) == 0)
      bus.aer_dis = ~bus.aer_dis;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    clr_in();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst = 1'b0;

    // single request, ack after 3 cycles
    run_txn(16'h0010, 3, 1'b0);
    check("single_lat", 32'(g_lat), 32'd1);
    check("single_addr", 32'(g_addr), 32'd4);
    check("single_grant", 32'(g_grant), 32'h0010);
    check("single_drop", 32'(g_drop), 32'd1);
    check("single_cnt", 32'(bus.evt_cnt), 32'd1);

    // round-robin between rows 0 and 15
    clr_in();
    do_reset();
    run_txn(16'h8001, 0, 1'b0);
    check("rr_0", 32'(g_addr), 32'd0);
    run_txn(16'h8001, 1, 1'b0);
    check("rr_1", 32'(g_addr), 32'd15);
    run_txn(16'h8001, 2, 1'b0);
    check("rr_2", 32'(g_addr), 32'd0);

    // wrap: serve 14, ptr lands on 15
    run_txn(16'h4000, 0, 1'b0);
    check("wrap_14", 32'(g_addr), 32'd14);
    run_txn(16'h0003, 0, 1'b0);
    check("wrap_0", 32'(g_addr), 32'd0);

    // greedy keeps row 0
    clr_in();
    do_reset();
    bus.greedy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_txn(16'h8001, i, 1'b0);
      check("greedy", 32'(g_addr), 32'd0);
    end
    check("greedy_cnt", 32'(bus.evt_cnt), 32'd3);

    // disable raised during ACK
    clr_in();
    do_reset();
    run_txn(16'h0006, 1, 1'b1);
    check("dis_first", 32'(g_addr), 32'd1);
    check("dis_cnt", 32'(bus.evt_cnt), 32'd1);
    repeat (6) step();
    check("dis_parked_req", 32'(bus.aer_req), 32'd0);
    check("dis_parked_busy", 32'(bus.busy), 32'd0);
    bus.aer_dis = 1'b0;
    run_txn(16'h0006, 0, 1'b0);
    check("dis_next", 32'(g_addr), 32'd2);

    // reset while in ACK
    bus.row_req = 16'h8002;
    step();
    check("mid_addr", 32'(bus.aer_addr), 32'd15);
    bus.aer_ack = 1'b1;
    step();
    check("mid_in_ack", 32'(bus.row_grant), 32'h8000);
    bus.aer_ack = 1'b0;
    do_reset();
    run_txn(16'h8002, 0, 1'b0);
    check("mid_after", 32'(g_addr), 32'd1);
    check("mid_cnt", 32'(bus.evt_cnt), 32'd1);

    // random traffic
    clr_in();
    for (int c = 0; c < 5000; c++) begin
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end else begin
        rnd_inputs();
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aer_row_scheduler_16.md
AER_ROW_SCHEDULER_16 -- requirements
Module: aer_row_scheduler_16

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high; one clock, no other reset.
REQ-003 row_req  input  16  per-row request (active high), driven by the row interface ro outputs.
REQ-004 greedy  input  1  1 = retain priority on last-served row; 0 = round-robin rotation.
REQ-005 aer_dis  input  1  1 = block new arbitration; in-flight handshake completes.
REQ-006 aer_ack  input  1  off-chip acknowledge, 4-phase, active high; synchronous to clk.
REQ-007 row_grant  output  16  one-hot grant back to the row interfaces (active high).
REQ-008 aer_req  output  1  off-chip request, 4-phase, active high.
REQ-009 aer_addr  output  4  encoded index of the granted row; valid while aer_req=1.
REQ-010 busy  output  1  1 whenever state != IDLE.
REQ-011 evt_cnt  output  16  count of completed handshakes, saturating.

Function
REQ-012 FSM states: IDLE, REQ, ACK, RELEASE; all outputs registered.
REQ-013 IDLE: if |row_req && !aer_dis, select winner w; next cycle row_grant=1<<w, aer_addr=w, aer_req=1, state REQ (1-cycle latency request->grant).
REQ-014 Winner: first asserted row_req at index >= ptr, searching ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
REQ-015 REQ: hold grant/addr/aer_req until aer_ack=1; then next cycle aer_req=0, state ACK.
REQ-016 ACK: hold row_grant and aer_addr until aer_ack=0; then next cycle row_grant=0, evt_cnt+1 (saturate at 16'hFFFF), ptr update, state RELEASE.
REQ-017 ptr update: greedy=0 -> ptr=w+1 with 15 wrapping to 0; greedy=1 -> ptr=w (unchanged winner keeps priority).
REQ-018 RELEASE: wait until row_req[w]=0; then state IDLE. Other rows' requests are ignored in RELEASE.
REQ-019 At most one row_grant bit high at any time; row_grant=0 in IDLE and RELEASE.
REQ-020 row_req changes on non-winning rows during REQ/ACK do not alter w, aer_addr or row_grant.
REQ-021 row_req[w] dropping during REQ or ACK does not abort; handshake completes normally.
REQ-022 aer_dis rising in REQ/ACK/RELEASE: current transaction completes; FSM then parks in IDLE while aer_dis=1.
REQ-023 aer_dis and row_req sampled in same IDLE cycle: aer_dis=1 wins, no grant.
REQ-024 aer_ack=1 in IDLE or RELEASE is ignored (no state change, no error).
REQ-025 Back-to-back: a new arbitration occurs earliest on the cycle IDLE is re-entered; minimum transaction period 4 cycles.
REQ-026 greedy sampled only at ptr update (REQ-016); mid-transaction changes take effect on next update.

Reset
REQ-027 rst=1 forces asynchronously: state=IDLE, ptr=0, row_grant=0, aer_req=0, aer_addr=0, busy=0, evt_cnt=0.
REQ-028 rst asserted mid-handshake aborts it; no count increment; after release the FSM starts from IDLE with ptr=0.
REQ-029 First arbitration is possible on the first rising edge after rst deasserts.

Verification
REQ-030 Single request: row_req=16'h0010, ack responds after 3 cycles -> row_grant=16'h0010, aer_addr=4, aer_req drops 1 cycle after ack, evt_cnt=1.
REQ-031 Round-robin: greedy=0, row_req=16'h8001 held, 3 transactions -> aer_addr sequence 0,15,0.
REQ-032 Greedy: greedy=1, row_req=16'h8001 held -> aer_addr sequence 0,0,0; toggling row 0 low then high keeps it winning over row 15.
REQ-033 Wrap: ptr=15 after serving row 14 (greedy=0), row_req=16'h0003 -> aer_addr=0.
REQ-034 aer_dis: aer_dis=1 during ACK with row_req=16'h0006 -> handshake completes, evt_cnt+1, no new aer_req until aer_dis=0, then aer_addr=1 or 2 per ptr.
REQ-035 Reset mid-op: rst pulse while in ACK -> all outputs 0 immediately, evt_cnt=0, next grant chosen from ptr=0.
